// File: rtl/phase_controller.sv
// Five-phase instruction sequencer for the SIMPLE core: phase strobes, memory handshake, SZCV flags, branch resolution.
// Optional `SINGLE_STEP_EN adds a step input that runs one instruction from HALTED and returns there.
module phase_controller #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] COMMAND,
  input  logic        write,
  input  logic        PC_load,
  input  logic [3:0]  flags_in,
  input  logic        mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [4:0]  phase,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load_en,
  output logic        reg_we,
  output logic        out_strobe,
  output logic [3:0]  flags,
  output logic        halted,
  output logic        mem_err
);

  localparam logic [2:0] S_HALT = 3'd0;
  localparam logic [2:0] S_P1   = 3'd1;
  localparam logic [2:0] S_P2   = 3'd2;
  localparam logic [2:0] S_P3   = 3'd3;
  localparam logic [2:0] S_P4   = 3'd4;
  localparam logic [2:0] S_P5   = 3'd5;

  logic [2:0]  state, state_nxt;
  logic [31:0] wait_cnt;
  logic        timeout;
  logic        step_stop;
  logic        cond_true;
  logic        unused_cmd;

  wire is_alu      = (COMMAND[15:14] == 2'b11);
  wire is_ld       = (COMMAND[15:14] == 2'b00);
  wire is_st       = (COMMAND[15:14] == 2'b01);
  wire is_hlt      = is_alu && (COMMAND[7:4] == 4'b1111);
  wire is_out      = is_alu && (COMMAND[7:4] == 4'b1110);
  wire flag_upd    = is_alu && (COMMAND[7:4] <= 4'b1011);
  wire branch_take = PC_load && ((COMMAND[15:11] == 5'b10100) ||
                                 ((COMMAND[15:11] == 5'b10111) && cond_true));

  assign unused_cmd = ^COMMAND[3:0];

  // flags layout is {S,Z,C,V}
  always_comb begin
    cond_true = 1'b0;
    case (COMMAND[10:8])
      3'b000:  cond_true = flags[2];
      3'b001:  cond_true = flags[3] ^ flags[0];
      3'b010:  cond_true = flags[2] | (flags[3] ^ flags[0]);
      3'b011:  cond_true = ~flags[2];
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load_en = 1'b0;
    reg_we     = 1'b0;
    out_strobe = 1'b0;
    case (state)
      S_HALT: begin
        if (!mem_err) begin
          if (run) state_nxt = S_P1;
`ifdef SINGLE_STEP_EN
          else if (step) state_nxt = S_P1;
`endif
        end
      end
      S_P1: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_P2;
        end
      end
      S_P2: state_nxt = S_P3;
      S_P3: state_nxt = S_P4;
      S_P4: begin
        if (is_ld || is_st) begin
          mem_req = 1'b1;
          mem_we  = is_st;
          if (mem_ready) state_nxt = S_P5;
        end else begin
          state_nxt = S_P5;
        end
      end
      S_P5: begin
        reg_we     = write;
        out_strobe = is_out;
        pc_load_en = branch_take;
        state_nxt  = (is_hlt || step_stop) ? S_HALT : S_P1;
      end
      default: state_nxt = S_HALT;
    endcase
    if (timeout) state_nxt = S_HALT;
  end

  // A ready arriving on the final permitted wait cycle still completes the access.
  assign timeout = (MEM_TIMEOUT != 0) && mem_req && !mem_ready &&
                   (wait_cnt == MEM_TIMEOUT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_HALT;
      flags    <= 4'b0000;
      mem_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_P3 && flag_upd) flags <= flags_in;
      if (timeout) mem_err <= 1'b1;
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : '0;
    end
  end

`ifdef SINGLE_STEP_EN
  logic step_mode;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_mode <= 1'b0;
    end else if (state == S_HALT && !mem_err) begin
      if (run)       step_mode <= 1'b0;
      else if (step) step_mode <= 1'b1;
    end
  end
  assign step_stop = step_mode;
`else
  assign step_stop = 1'b0;
`endif

  assign phase  = {state == S_P5, state == S_P4, state == S_P3, state == S_P2, state == S_P1};
  assign halted = (state == S_HALT);

endmodule

// File: doc/phase_controller.md
# phase_controller

Multi-cycle sequencer for the 16-bit SIMPLE core. It walks each instruction through five phases: fetch, register read, ALU execute, memory, writeback. It drives the enables for the instruction register, PC, register file and memory port, and handles the memory ready handshake. It holds the SZCV condition flags and resolves conditional branches. It sits between the instruction register / instruction decoder outputs and the datapath registers.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 0: when non-zero, the number of cycles a memory request may wait before `mem_err` is asserted. 0 disables the check.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  start/resume pulse; honoured only in HALTED.
- `COMMAND`  in  16  current IR contents; valid from P2 onward.
- `write`  in  1  decoder register-write request.
- `PC_load`  in  1  decoder branch indication.
- `flags_in`  in  4  ALU {S,Z,C,V} for the current operation.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `step`  in  1  single-step pulse; present only with `SINGLE_STEP_EN`.
- `phase`  out  5  one-hot {P5..P1}; all zero in HALTED.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write qualifier; only meaningful with `mem_req`.
- `ir_load`  out  1  load IR from memory data.
- `pc_inc`  out  1  PC <= PC+1.
- `pc_load_en`  out  1  PC <= branch target.
- `reg_we`  out  1  register file write.
- `out_strobe`  out  1  OUT instruction data valid.
- `flags`  out  4  latched {S,Z,C,V}.
- `halted`  out  1  controller is in HALTED.
- `mem_err`  out  1  sticky memory timeout.

## Operation
- States: HALTED, P1, P2, P3, P4, P5. Reset enters HALTED.
- HALTED: `run`=1 moves to P1 on the next edge.
- P1 (fetch):
  - `mem_req`=1 and `mem_we`=0 until `mem_ready`=1.
  - In the `mem_ready` cycle, `ir_load`=1 and `pc_inc`=1, and the next state is P2.
- P2 (register read): one cycle, no strobes; next state is P3.
- P3 (execute): one cycle.
  - `flags` <= `flags_in` when `COMMAND[15:14]`=11 and `COMMAND[7:4]`<=1011.
  - Otherwise `flags` holds.
- P4 (memory):
  - LD (`COMMAND[15:14]`=00): `mem_req`=1, `mem_we`=0.
  - ST (`COMMAND[15:14]`=01): `mem_req`=1, `mem_we`=1.
  - Either request is held until `mem_ready`, then the next state is P5.
  - All other classes: one cycle, then P5.
- P5 (writeback): one cycle.
  - `reg_we` = `write`.
  - `out_strobe`=1 when `COMMAND[15:14]`=11 and `COMMAND[7:4]`=1110.
  - `pc_load_en`=1 when `PC_load`=1 and either:
    - `COMMAND[15:11]`=10100 (unconditional), or
    - `COMMAND[15:11]`=10111 and the condition on `COMMAND[10:8]` is true, evaluated against the latched `flags`: 000 Z; 001 S^V; 010 Z|(S^V); 011 !Z; others false.
  - HLT (`COMMAND[15:14]`=11, `COMMAND[7:4]`=1111) goes to HALTED; otherwise the next state is P1.
- All strobes are combinational on state and inputs and are zero outside the phases listed above.
- `run` outside HALTED is ignored.
- Timeout: with `MEM_TIMEOUT`=N>0, a counter runs while `mem_req`=1 and clears on `mem_ready`.
  - Reaching N sets `mem_err`=1 and forces HALTED; `mem_req` drops.
  - `mem_err` clears only on `reset`.
  - While `mem_err`=1, `run` is ignored.

## Timing
- Reset values: state HALTED, `phase`=00000, `flags`=0000, `halted`=1, `mem_err`=0, all strobes 0.
- Reset is asynchronous and aborts any phase, including an outstanding memory request, which is dropped immediately.
- Instruction latency with zero-wait memory (`mem_ready` high in the first request cycle): 5 cycles, P1 through P5.
  - Each memory wait cycle adds 1 cycle to its phase.
- `halted` rises in the cycle after a HLT completes P5.
- `run` asserted in the HALTED cycle gives `phase`=00001 on the next cycle.
- `mem_ready` while `mem_req`=0 is ignored.
- A `mem_ready` in the same cycle that the timeout count hits N counts as completion; no error is raised.

## Configuration
- `SINGLE_STEP_EN` defined:
  - The `step` port exists.
  - `step`=1 in HALTED runs exactly one instruction (P1..P5) and then returns to HALTED, regardless of opcode.
  - `run` keeps free-running behaviour.
  - If `run` and `step` are asserted together, `run` wins.
- `SINGLE_STEP_EN` undefined: no `step` port; only `run` leaves HALTED.

## Test plan
- Zero-wait ADD (`COMMAND`=0xC100, `write`=1, `flags_in`=0100) after `run` -> `phase` 00001→00010→00100→01000→10000; `reg_we`=1 in P5 only; `flags`=0100 after P3.
- ST (`COMMAND`=0x4000), `mem_ready` delayed 3 cycles in P4 -> `mem_req`=`mem_we`=1 for 4 cycles; P5 on the next edge; `reg_we`=0.
- Branch BE (`COMMAND`=0xB800, `PC_load`=1) with Z=1 -> `pc_load_en`=1 in P5; with Z=0 -> `pc_load_en`=0 and `pc_inc` only in P1.
- HLT (`COMMAND`=0xC0F0) -> `halted`=1 after P5; a later `run` resumes at P1.
- Reset asserted mid-P4 with `mem_req`=1 -> same-cycle `mem_req`=0, `phase`=00000, `halted`=1, `flags`=0000.
- `MEM_TIMEOUT`=4 with `mem_ready` held low in P1 -> `mem_err`=1 after 4 request cycles; HALTED; `run` ignored until `reset`.
